// File: rtl/sd_audio_streamer.sv
// Streams sequential SD card blocks into a byte FIFO and plays them out
// as unsigned 8-bit samples at a fixed rate set by a clock divider.
module sd_audio_streamer #(
  parameter int          FIFO_DEPTH  = 1024,
  parameter int          BLOCK_BYTES = 512,
  parameter int          SAMPLE_DIV  = 3125,
  parameter logic [31:0] START_ADDR  = 32'd0,
  parameter int          NUM_BLOCKS  = 2048
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          sd_ready,
  output logic                          sd_rd,
  output logic [31:0]                   sd_address,
  input  logic [7:0]                    sd_dout,
  input  logic                          sd_byte_available,
  output logic [7:0]                    sample,
  output logic                          sample_valid,
  output logic                          underrun,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BCW = $clog2(BLOCK_BYTES) + 1;
  localparam int NBW = $clog2(NUM_BLOCKS) + 1;
  localparam int DW  = $clog2(SAMPLE_DIV) + 1;

  localparam logic [LW-1:0]  FULL_LEVEL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]  BLOCK_LEVEL = LW'(BLOCK_BYTES);
  localparam logic [LW-1:0]  ISSUE_MAX   = LW'(FIFO_DEPTH - BLOCK_BYTES);
  localparam logic [BCW-1:0] LAST_BYTE   = BCW'(BLOCK_BYTES - 1);
  localparam logic [NBW-1:0] LAST_BLOCK  = NBW'(NUM_BLOCKS - 1);
  localparam logic [DW-1:0]  DIV_LAST    = DW'(SAMPLE_DIV - 1);
  localparam logic [31:0]    BLOCK_STEP  = 32'(BLOCK_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_READ,
    S_NEXT,
    S_WAIT
  } state_t;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [LW-1:0]  level_q;
  logic [LW-1:0]  level_d;
  logic           strobe_q;
  logic           playing_q;
  logic [DW-1:0]  div_q;
  logic [7:0]     sample_q;
  logic           valid_q;
  logic           underrun_q;
  logic           overflow_q;

  state_t         state_q;
  logic           rd_q;
  logic [31:0]    addr_q;
  logic [BCW-1:0] byte_cnt_q;
  logic [NBW-1:0] blk_cnt_q;

  logic strobe_rise;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic tick;
  logic pop;

  always_comb begin
    strobe_rise = sd_byte_available & ~strobe_q;
    fifo_full   = (level_q == FULL_LEVEL);
    fifo_empty  = (level_q == '0);
    push        = strobe_rise & ~fifo_full;
    tick        = playing_q & (div_q == DIV_LAST);
    pop         = tick & ~fifo_empty;
    level_d     = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // Storage only, no reset, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= sd_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      playing_q  <= 1'b0;
      div_q      <= '0;
      sample_q   <= 8'h80;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q <= sd_byte_available;
      level_q  <= level_d;
      valid_q  <= tick;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (strobe_rise && fifo_full) begin
        overflow_q <= 1'b1;
      end
      if (!enable) begin
        playing_q <= 1'b0;
      end else if (level_q >= BLOCK_LEVEL) begin
        playing_q <= 1'b1;
      end
      if (!playing_q || div_q == DIV_LAST) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + DW'(1);
      end
      // An empty tick still pulses valid so the PWM sees a steady rate.
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        sample_q <= mem[rd_ptr_q];
      end else if (tick) begin
        sample_q   <= 8'h80;
        underrun_q <= 1'b1;
      end else if (!playing_q) begin
        sample_q <= 8'h80;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      addr_q     <= START_ADDR;
      byte_cnt_q <= '0;
      blk_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable && sd_ready && level_q <= ISSUE_MAX) begin
            state_q <= S_ISSUE;
            rd_q    <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Acceptance wins over a late disable: the read is already underway.
          if (!sd_ready) begin
            rd_q       <= 1'b0;
            byte_cnt_q <= '0;
            state_q    <= S_READ;
          end else if (!enable) begin
            rd_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_READ: begin
          if (strobe_rise) begin
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q <= '0;
              state_q    <= S_NEXT;
            end else begin
              byte_cnt_q <= byte_cnt_q + BCW'(1);
            end
          end
        end
        S_NEXT: begin
          if (blk_cnt_q == LAST_BLOCK) begin
            blk_cnt_q <= '0;
            addr_q    <= START_ADDR;
          end else begin
            blk_cnt_q <= blk_cnt_q + NBW'(1);
            addr_q    <= addr_q + BLOCK_STEP;
          end
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (sd_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rd_q    <= 1'b0;
        end
      endcase
    end
  end

  assign sd_rd        = rd_q;
  assign sd_address   = addr_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign underrun     = underrun_q;
  assign overflow     = overflow_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_sd_audio_streamer.sv
// Bench for sd_audio_streamer: a behavioural SD card serves blocks whose bytes
// equal their card address, and a queue model predicts every sample and level.
module tb_sd_audio_streamer;

  localparam int DEPTH = 1024;
  localparam int BLK   = 512;
  localparam int DIV   = 4;
  localparam int NBLK  = 3;
  localparam int STALL = 3000;
  localparam int RD_WAIT_MAX = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sd_ready = 1'b0;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout = 8'h00;
  logic        sd_byte_available = 1'b0;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        underrun;
  logic        overflow;
  logic [10:0] fifo_level;

  sd_audio_streamer #(
    .FIFO_DEPTH (DEPTH),
    .BLOCK_BYTES(BLK),
    .SAMPLE_DIV (DIV),
    .START_ADDR (32'd0),
    .NUM_BLOCKS (NBLK)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .sd_ready         (sd_ready),
    .sd_rd            (sd_rd),
    .sd_address       (sd_address),
    .sd_dout          (sd_dout),
    .sd_byte_available(sd_byte_available),
    .sample           (sample),
    .sample_valid     (sample_valid),
    .underrun         (underrun),
    .overflow         (overflow),
    .fifo_level       (fifo_level)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  typedef struct {
    logic [7:0] data;
    longint     cyc;
  } entry_t;

  entry_t q[$];
  entry_t new_e;
  longint cyc = 0;
  longint tick_cyc;
  longint last_valid = -1;
  logic   prev_strobe = 1'b0;
  logic   ovf_exp = 1'b0;
  logic   und_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model push side: a byte is stored when the strobe rises and the FIFO is not full.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      q.delete();
      prev_strobe <= 1'b0;
      ovf_exp     <= 1'b0;
    end else begin
      prev_strobe <= sd_byte_available;
      if (sd_byte_available && !prev_strobe) begin
        if (q.size() >= DEPTH) begin
          ovf_exp <= 1'b1;
        end else begin
          new_e.data = sd_dout;
          new_e.cyc  = cyc;
          q.push_back(new_e);
        end
      end
    end
  end

  // Model pop side: a byte stored at cycle p can be played from cycle p+1 on.
  always @(negedge clk) begin
    if (reset) begin
      und_exp    = 1'b0;
      last_valid = -1;
    end else begin
      if (sample_valid) begin
        tick_cyc = cyc - 1;
        if (q.size() > 0 && q[0].cyc < tick_cyc) begin
          check("sample", 32'(sample), 32'(q[0].data));
          void'(q.pop_front());
        end else begin
          und_exp = 1'b1;
          check("empty_tick_sample", 32'(sample), 32'h80);
        end
        check("underrun", 32'(underrun), 32'(und_exp));
        if (last_valid >= 0) begin
          check("sample_period", 32'(tick_cyc - last_valid), 32'(DIV));
        end
        last_valid = tick_cyc;
      end
      if (!enable) last_valid = -1;
      check("fifo_level", 32'(fifo_level), 32'(q.size()));
      check("overflow", 32'(overflow), 32'(ovf_exp));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    sd_byte_available = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic direct_push(input logic [7:0] b);
    sd_dout = b;
    sd_byte_available = 1'b1;
    @(negedge clk);
    sd_byte_available = 1'b0;
    @(negedge clk);
  endtask

  // Behavioural SD card: accept one request, then stream BLK bytes.
  task automatic serve_block(input int len, input int stall_at, input logic [31:0] exp_addr);
    int n;
    logic [31:0] a;
    n = 0;
    while (sd_rd !== 1'b1 && n < RD_WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check("rd_request_seen", 32'(n < RD_WAIT_MAX), 32'd1);
    if (n >= RD_WAIT_MAX) return;
    check("sd_address", sd_address, exp_addr);
    a = sd_address;
    repeat (2) @(negedge clk);
    check("rd_held_in_issue", 32'(sd_rd), 32'd1);
    sd_ready = 1'b0;
    @(negedge clk);
    check("rd_drop_on_accept", 32'(sd_rd), 32'd0);
    for (int i = 0; i < BLK; i++) begin
      if (i == stall_at) repeat (STALL) @(negedge clk);
      sd_dout = 8'(a + 32'(i));
      sd_byte_available = 1'b1;
      repeat (len) @(negedge clk);
      sd_byte_available = 1'b0;
      repeat (1 + $urandom_range(0, 1)) @(negedge clk);
      if (i % 64 == 0) check("rd_low_in_read", 32'(sd_rd), 32'd0);
    end
    repeat (3) @(negedge clk);
    check("no_issue_before_ready", 32'(sd_rd), 32'd0);
    sd_ready = 1'b1;
  endtask

  initial begin
    int n;
    // Streaming run: five blocks, address wrap after three, one long stall.
    sd_ready = 1'b1;
    do_reset();
    check("rst_sd_rd", 32'(sd_rd), 32'd0);
    check("rst_sd_address", sd_address, 32'd0);
    check("rst_sample", 32'(sample), 32'h80);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);

    enable = 1'b1;
    for (int b = 0; b < 5; b++) begin
      serve_block((b == 1) ? 3 : 1, (b == 2) ? 10 : -1, 32'((b % NBLK) * BLK));
      if (b == 2) check("underrun_after_stall", 32'(underrun), 32'd1);
    end
    repeat (20) @(negedge clk);
    check("underrun_sticky", 32'(underrun), 32'd1);

    // Overflow: fill with playback off, then one more byte.
    sd_ready = 1'b0;
    do_reset();
    for (int i = 0; i < DEPTH; i++) direct_push(8'($urandom));
    check("full_level", 32'(fifo_level), 32'd1024);
    check("full_no_overflow", 32'(overflow), 32'd0);
    direct_push(8'($urandom));
    check("ovf_level", 32'(fifo_level), 32'd1024);
    check("ovf_flag", 32'(overflow), 32'd1);

    // Simultaneous push and pop at level 600.
    do_reset();
    for (int i = 0; i < 601; i++) direct_push(8'($urandom));
    check("pre_play_level", 32'(fifo_level), 32'd601);
    enable = 1'b1;
    n = 0;
    while (sample_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("first_tick_seen", 32'(n < 50), 32'd1);
    check("level_600", 32'(fifo_level), 32'd600);
    repeat (3) @(negedge clk);
    sd_dout = 8'hA5;
    sd_byte_available = 1'b1;
    @(negedge clk);
    check("coincide_tick", 32'(sample_valid), 32'd1);
    check("coincide_level", 32'(fifo_level), 32'd600);
    sd_byte_available = 1'b0;
    enable = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_sample", 32'(sample), 32'h80);
    repeat (8) @(negedge clk);
    check("idle_no_valid", 32'(sample_valid), 32'd0);
    check("idle_sd_rd", 32'(sd_rd), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
